// File: rtl/ifex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifex_pkg
// Purpose  : Shared constants and ALU operation encodings for the
//            decode-to-execute pipeline register and its ALU chain.
// Contents : BUS_WIDTH_DEF, REGISTER_DEF, ALU_FUNCT_BITS_DEF width constants;
//            alu1_op_e (parent ALU codes); alu2_op_e (child ALU codes).
// Revision : 1.0  initial release
// ============================================================================
package ifex_pkg;

  localparam int unsigned BUS_WIDTH_DEF      = 32;
  localparam int unsigned REGISTER_DEF       = 6;
  localparam int unsigned ALU_FUNCT_BITS_DEF = 3;

  // Parent ALU: operates on Src1A and the selected operand B.
  typedef enum logic [ALU_FUNCT_BITS_DEF-1:0] {
    ALU1_ADD   = 3'b000,
    ALU1_SUB   = 3'b001,
    ALU1_MUL   = 3'b010,
    ALU1_AND   = 3'b011,
    ALU1_OR    = 3'b100,
    ALU1_SLT   = 3'b101,
    ALU1_PASSA = 3'b110,
    ALU1_PASSB = 3'b111
  } alu1_op_e;

  // Child ALU: operates on the parent result P and Src1C.
  typedef enum logic [ALU_FUNCT_BITS_DEF-1:0] {
    ALU2_PASSP = 3'b000,
    ALU2_ADD   = 3'b001,
    ALU2_SUB   = 3'b010,
    ALU2_RELU  = 3'b011,
    ALU2_MAX   = 3'b100,
    ALU2_MIN   = 3'b101,
    ALU2_SRA   = 3'b110,
    ALU2_PASSC = 3'b111
  } alu2_op_e;

endpackage : ifex_pkg
`default_nettype wire

// File: rtl/ifex_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : ifex_alu_core
// Purpose  : Purely combinational execute datapath: operand-B mux, parent
//            ALU and the child ALU chained behind it.
// Ports    : i_alu1_src    - 1 selects i_sign_imm as operand B, 0 i_src_b
//            i_alu1_cntrl  - parent ALU function code
//            i_alu2_cntrl  - child ALU function code
//            i_src_a/b/c   - register operands
//            i_sign_imm    - sign-extended immediate
//            o_alu_out1    - parent result
//            o_alu_out2    - child result (memory address / write-back)
// Config   : IFEX_MUL_EN - when defined the parent multiply is built;
//            otherwise parent code 010 yields zero and no multiplier exists.
// Revision : 1.0  initial release
// ============================================================================
module ifex_alu_core
  import ifex_pkg::*;
#(
  parameter int BUS_WIDTH      = BUS_WIDTH_DEF,
  parameter int ALU_FUNCT_BITS = ALU_FUNCT_BITS_DEF
) (
  input  logic                      i_alu1_src,
  input  logic [ALU_FUNCT_BITS-1:0] i_alu1_cntrl,
  input  logic [ALU_FUNCT_BITS-1:0] i_alu2_cntrl,
  input  logic [BUS_WIDTH-1:0]      i_src_a,
  input  logic [BUS_WIDTH-1:0]      i_src_b,
  input  logic [BUS_WIDTH-1:0]      i_src_c,
  input  logic [BUS_WIDTH-1:0]      i_sign_imm,
  output logic [BUS_WIDTH-1:0]      o_alu_out1,
  output logic [BUS_WIDTH-1:0]      o_alu_out2
);

  alu1_op_e             w_op1;
  alu2_op_e             w_op2;
  logic [BUS_WIDTH-1:0] w_op_b;
  logic [BUS_WIDTH-1:0] w_p;
  logic [BUS_WIDTH-1:0] w_q;
  logic                 w_lt_ab;
  logic                 w_lt_pc;

  assign w_op1  = alu1_op_e'(i_alu1_cntrl);
  assign w_op2  = alu2_op_e'(i_alu2_cntrl);
  assign w_op_b = i_alu1_src ? i_sign_imm : i_src_b;

  // Two's-complement comparisons shared by SLT and by MAX/MIN.
  assign w_lt_ab = $signed(i_src_a) < $signed(w_op_b);
  assign w_lt_pc = $signed(w_p) < $signed(i_src_c);

  // Parent ALU. Add/sub/mul are truncated to BUS_WIDTH, i.e. wrap.
  always_comb begin
    w_p = '0;
    case (w_op1)
      ALU1_ADD:   w_p = i_src_a + w_op_b;
      ALU1_SUB:   w_p = i_src_a - w_op_b;
      ALU1_MUL: begin
`ifdef IFEX_MUL_EN
        w_p = i_src_a * w_op_b;
`else
        w_p = '0;
`endif
      end
      ALU1_AND:   w_p = i_src_a & w_op_b;
      ALU1_OR:    w_p = i_src_a | w_op_b;
      ALU1_SLT:   w_p = {{(BUS_WIDTH-1){1'b0}}, w_lt_ab};
      ALU1_PASSA: w_p = i_src_a;
      ALU1_PASSB: w_p = w_op_b;
      default:    w_p = '0;
    endcase
  end

  // Child ALU, fed by the parent result.
  always_comb begin
    w_q = '0;
    case (w_op2)
      ALU2_PASSP: w_q = w_p;
      ALU2_ADD:   w_q = w_p + i_src_c;
      ALU2_SUB:   w_q = w_p - i_src_c;
      ALU2_RELU:  w_q = w_p[BUS_WIDTH-1] ? '0 : w_p;
      ALU2_MAX:   w_q = w_lt_pc ? i_src_c : w_p;
      ALU2_MIN:   w_q = w_lt_pc ? w_p : i_src_c;
      ALU2_SRA:   w_q = $signed(w_p) >>> i_src_c[4:0];
      ALU2_PASSC: w_q = i_src_c;
      default:    w_q = '0;
    endcase
  end

  assign o_alu_out1 = w_p;
  assign o_alu_out2 = w_q;

endmodule : ifex_alu_core
`default_nettype wire

// File: rtl/ifex_reg.sv
`default_nettype none
// ============================================================================
// Module   : ifex_reg
// Purpose  : Decode-to-execute pipeline register. Captures the decode-stage
//            control bits and operands every rising CLK edge (no stall) and
//            drives the execute datapath combinationally from those copies.
// Ports    : CLK, RST_N          - clock, asynchronous active-low reset
//            *D inputs           - decode-stage controls, codes, operands
//            PCEn ... Rd         - registered copies of the *D inputs
//            WriteDstReg         - Rd when RegDst=1, else Rt
//            ALUOut1 / ALUOut2   - parent / child ALU results
// Reset    : all registers clear to 0 except PCEn which resets to 1, giving
//            a bubble that still lets fetch advance.
// Config   : IFEX_MUL_EN - enables the parent multiplier (see ifex_alu_core).
// Revision : 1.0  initial release
// ============================================================================
module ifex_reg
  import ifex_pkg::*;
#(
  parameter int BUS_WIDTH      = BUS_WIDTH_DEF,
  parameter int REGISTER       = REGISTER_DEF,
  parameter int ALU_FUNCT_BITS = ALU_FUNCT_BITS_DEF
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      PCEnD,
  input  logic                      RegWriteD,
  input  logic                      ALU1SrcD,
  input  logic                      RegDstD,
  input  logic                      MemWriteD,
  input  logic                      MemtoRegD,
  input  logic [ALU_FUNCT_BITS-1:0] ALU1CntrlD,
  input  logic [ALU_FUNCT_BITS-1:0] ALU2CntrlD,
  input  logic [BUS_WIDTH-1:0]      Src1AD,
  input  logic [BUS_WIDTH-1:0]      Src1BD,
  input  logic [BUS_WIDTH-1:0]      Src1CD,
  input  logic [BUS_WIDTH-1:0]      SignImmD,
  input  logic [REGISTER-1:0]       RtD,
  input  logic [REGISTER-1:0]       RdD,
  output logic                      PCEn,
  output logic                      RegWrite,
  output logic                      ALU1Src,
  output logic                      RegDst,
  output logic                      MemWrite,
  output logic                      MemtoReg,
  output logic [ALU_FUNCT_BITS-1:0] ALU1Cntrl,
  output logic [ALU_FUNCT_BITS-1:0] ALU2Cntrl,
  output logic [BUS_WIDTH-1:0]      Src1A,
  output logic [BUS_WIDTH-1:0]      Src1B,
  output logic [BUS_WIDTH-1:0]      Src1C,
  output logic [BUS_WIDTH-1:0]      SignImm,
  output logic [REGISTER-1:0]       Rt,
  output logic [REGISTER-1:0]       Rd,
  output logic [REGISTER-1:0]       WriteDstReg,
  output logic [BUS_WIDTH-1:0]      ALUOut1,
  output logic [BUS_WIDTH-1:0]      ALUOut2
);

  logic                      r_pc_en;
  logic                      r_reg_write;
  logic                      r_alu1_src;
  logic                      r_reg_dst;
  logic                      r_mem_write;
  logic                      r_mem_to_reg;
  logic [ALU_FUNCT_BITS-1:0] r_alu1_cntrl;
  logic [ALU_FUNCT_BITS-1:0] r_alu2_cntrl;
  logic [BUS_WIDTH-1:0]      r_src_a;
  logic [BUS_WIDTH-1:0]      r_src_b;
  logic [BUS_WIDTH-1:0]      r_src_c;
  logic [BUS_WIDTH-1:0]      r_sign_imm;
  logic [REGISTER-1:0]       r_rt;
  logic [REGISTER-1:0]       r_rd;

  logic [BUS_WIDTH-1:0]      w_alu_out1;
  logic [BUS_WIDTH-1:0]      w_alu_out2;

  // PCEn resets high so the front end keeps fetching while this stage
  // holds a bubble (no register or memory write).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pc_en      <= 1'b1;
      r_reg_write  <= 1'b0;
      r_alu1_src   <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu1_cntrl <= '0;
      r_alu2_cntrl <= '0;
      r_src_a      <= '0;
      r_src_b      <= '0;
      r_src_c      <= '0;
      r_sign_imm   <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
    end else begin
      r_pc_en      <= PCEnD;
      r_reg_write  <= RegWriteD;
      r_alu1_src   <= ALU1SrcD;
      r_reg_dst    <= RegDstD;
      r_mem_write  <= MemWriteD;
      r_mem_to_reg <= MemtoRegD;
      r_alu1_cntrl <= ALU1CntrlD;
      r_alu2_cntrl <= ALU2CntrlD;
      r_src_a      <= Src1AD;
      r_src_b      <= Src1BD;
      r_src_c      <= Src1CD;
      r_sign_imm   <= SignImmD;
      r_rt         <= RtD;
      r_rd         <= RdD;
    end
  end

  ifex_alu_core #(
    .BUS_WIDTH      (BUS_WIDTH),
    .ALU_FUNCT_BITS (ALU_FUNCT_BITS)
  ) u_alu_core (
    .i_alu1_src   (r_alu1_src),
    .i_alu1_cntrl (r_alu1_cntrl),
    .i_alu2_cntrl (r_alu2_cntrl),
    .i_src_a      (r_src_a),
    .i_src_b      (r_src_b),
    .i_src_c      (r_src_c),
    .i_sign_imm   (r_sign_imm),
    .o_alu_out1   (w_alu_out1),
    .o_alu_out2   (w_alu_out2)
  );

  assign PCEn        = r_pc_en;
  assign RegWrite    = r_reg_write;
  assign ALU1Src     = r_alu1_src;
  assign RegDst      = r_reg_dst;
  assign MemWrite    = r_mem_write;
  assign MemtoReg    = r_mem_to_reg;
  assign ALU1Cntrl   = r_alu1_cntrl;
  assign ALU2Cntrl   = r_alu2_cntrl;
  assign Src1A       = r_src_a;
  assign Src1B       = r_src_b;
  assign Src1C       = r_src_c;
  assign SignImm     = r_sign_imm;
  assign Rt          = r_rt;
  assign Rd          = r_rd;
  assign WriteDstReg = r_reg_dst ? r_rd : r_rt;
  assign ALUOut1     = w_alu_out1;
  assign ALUOut2     = w_alu_out2;

endmodule : ifex_reg
`default_nettype wire

// File: tb/tb_ifex_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifex_reg
// Purpose  : Self-checking bench for ifex_reg. Each stimulus vector pushes
//            its expected execute results to a scoreboard queue; after the
//            capturing clock edge the entry is popped and compared.
// Revision : 1.0  initial release
// ============================================================================
module tb_ifex_reg;

  localparam int BW = 32;
  localparam int RW = 6;
  localparam int FW = 3;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          PCEnD = 1'b0, RegWriteD = 1'b0, ALU1SrcD = 1'b0;
  logic          RegDstD = 1'b0, MemWriteD = 1'b0, MemtoRegD = 1'b0;
  logic [FW-1:0] ALU1CntrlD = '0, ALU2CntrlD = '0;
  logic [BW-1:0] Src1AD = '0, Src1BD = '0, Src1CD = '0, SignImmD = '0;
  logic [RW-1:0] RtD = '0, RdD = '0;

  logic          PCEn, RegWrite, ALU1Src, RegDst, MemWrite, MemtoReg;
  logic [FW-1:0] ALU1Cntrl, ALU2Cntrl;
  logic [BW-1:0] Src1A, Src1B, Src1C, SignImm;
  logic [RW-1:0] Rt, Rd, WriteDstReg;
  logic [BW-1:0] ALUOut1, ALUOut2;

  ifex_reg #(.BUS_WIDTH(BW), .REGISTER(RW), .ALU_FUNCT_BITS(FW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .PCEnD(PCEnD), .RegWriteD(RegWriteD), .ALU1SrcD(ALU1SrcD),
    .RegDstD(RegDstD), .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
    .ALU1CntrlD(ALU1CntrlD), .ALU2CntrlD(ALU2CntrlD),
    .Src1AD(Src1AD), .Src1BD(Src1BD), .Src1CD(Src1CD), .SignImmD(SignImmD),
    .RtD(RtD), .RdD(RdD),
    .PCEn(PCEn), .RegWrite(RegWrite), .ALU1Src(ALU1Src), .RegDst(RegDst),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .ALU1Cntrl(ALU1Cntrl), .ALU2Cntrl(ALU2Cntrl),
    .Src1A(Src1A), .Src1B(Src1B), .Src1C(Src1C), .SignImm(SignImm),
    .Rt(Rt), .Rd(Rd), .WriteDstReg(WriteDstReg),
    .ALUOut1(ALUOut1), .ALUOut2(ALUOut2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string         tag;
    logic [BW-1:0] out1;
    logic [BW-1:0] out2;
    logic [RW-1:0] wdst;
    logic          memwrite;
    logic          regwrite;
    logic          pcen;
    logic [BW-1:0] src_a;
  } exp_t;

  exp_t scoreboard[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [BW-1:0] obs,
                           input logic [BW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Independent reference of the execute stage, written from the op tables.
  function automatic logic [BW-1:0] ref_alu1(input logic [2:0] op,
                                             input logic [BW-1:0] a,
                                             input logic [BW-1:0] b);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      3'd0: return a + b;
`ifdef IFEX_MUL_EN
      3'd2: return prod[31:0];
`else
      3'd2: return (prod == 64'd0) ? 32'd0 : 32'd0;
`endif
      3'd1: return a + ~b + 32'd1;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      3'd6: return a;
      default: return b;
    endcase
  endfunction

  function automatic logic [BW-1:0] ref_alu2(input logic [2:0] op,
                                             input logic [BW-1:0] p,
                                             input logic [BW-1:0] c);
    logic [BW-1:0] r;
    case (op)
      3'd0: return p;
      3'd1: return p + c;
      3'd2: return p + ~c + 32'd1;
      3'd3: return p[31] ? 32'd0 : p;
      3'd4: return ((p ^ 32'h8000_0000) >= (c ^ 32'h8000_0000)) ? p : c;
      3'd5: return ((p ^ 32'h8000_0000) <= (c ^ 32'h8000_0000)) ? p : c;
      3'd6: begin
        r = p;
        for (int i = 0; i < int'(c[4:0]); i++) r = {r[31], r[31:1]};
        return r;
      end
      default: return c;
    endcase
  endfunction

  // Drive one decode-stage vector on the falling edge, enqueue its
  // expectation, then compare just after the capturing rising edge.
  task automatic apply(input string tag,
                       input logic alu1src, input logic regdst,
                       input logic memwrite, input logic regwrite,
                       input logic [2:0] a1, input logic [2:0] a2,
                       input logic [BW-1:0] a, input logic [BW-1:0] b,
                       input logic [BW-1:0] c, input logic [BW-1:0] imm,
                       input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                       input logic [BW-1:0] e1, input logic [BW-1:0] e2);
    exp_t e;
    @(negedge CLK);
    PCEnD = 1'b1; RegWriteD = regwrite; ALU1SrcD = alu1src;
    RegDstD = regdst; MemWriteD = memwrite; MemtoRegD = 1'b0;
    ALU1CntrlD = a1; ALU2CntrlD = a2;
    Src1AD = a; Src1BD = b; Src1CD = c; SignImmD = imm;
    RtD = rt; RdD = rd;
    e.tag = tag; e.out1 = e1; e.out2 = e2;
    e.wdst = regdst ? rd : rt;
    e.memwrite = memwrite; e.regwrite = regwrite; e.pcen = 1'b1;
    e.src_a = a;
    scoreboard.push_back(e);
    @(posedge CLK);
    #1;
    if (scoreboard.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = scoreboard.pop_front();
      check_val({e.tag, "_out1"}, ALUOut1, e.out1);
      check_val({e.tag, "_out2"}, ALUOut2, e.out2);
      check_val({e.tag, "_wdst"}, {26'd0, WriteDstReg}, {26'd0, e.wdst});
      check_val({e.tag, "_memwr"}, {31'd0, MemWrite}, {31'd0, e.memwrite});
      check_val({e.tag, "_regwr"}, {31'd0, RegWrite}, {31'd0, e.regwrite});
      check_val({e.tag, "_pcen"}, {31'd0, PCEn}, {31'd0, e.pcen});
      check_val({e.tag, "_srca"}, Src1A, e.src_a);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [BW-1:0] ra, rb, rc, ri, e1;
    logic [2:0]    o1, o2;
    logic          s;

    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    // Reset state while held.
    check_val("rst_pcen", {31'd0, PCEn}, 32'd1);
    check_val("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check_val("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check_val("rst_aluout2", ALUOut2, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Load/store address generation.
    apply("ldst", 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000,
          32'd100, 32'd0, 32'd0, 32'd8, 6'd0, 6'd0, 32'd108, 32'd108);

    // Multiply-accumulate.
`ifdef IFEX_MUL_EN
    apply("mac", 1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 3'b001,
          32'd3, 32'd5, 32'd7, 32'd0, 6'd1, 6'd2, 32'd15, 32'd22);
`else
    apply("mac", 1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 3'b001,
          32'd3, 32'd5, 32'd7, 32'd0, 6'd1, 6'd2, 32'd0, 32'd7);
`endif

    // ReLU on a negative then positive difference.
    apply("relu_neg", 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 3'b011,
          32'd2, 32'd9, 32'd0, 32'd0, 6'd3, 6'd4, 32'hFFFF_FFF9, 32'd0);
    apply("relu_pos", 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 3'b011,
          32'd9, 32'd2, 32'd0, 32'd0, 6'd3, 6'd4, 32'd7, 32'd7);

    // Destination mux toggling.
    apply("dst_rd", 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 3'b000,
          32'd0, 32'd0, 32'd0, 32'd0, 6'd5, 6'd12, 32'd0, 32'd0);
    apply("dst_rt", 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000,
          32'd0, 32'd0, 32'd0, 32'd0, 6'd5, 6'd12, 32'd0, 32'd0);

    // Add wrap-around.
    apply("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000,
          32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 6'd0, 6'd0, 32'd0, 32'd0);

    // Signed compare with the most negative value.
    apply("slt_min", 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 3'b000,
          32'h8000_0000, 32'd1, 32'd0, 32'd0, 6'd0, 6'd0, 32'd1, 32'd1);

    // Arithmetic shift right of a negative value.
    apply("sra", 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 3'b110,
          32'h8000_0000, 32'd1, 32'd4, 32'd0, 6'd0, 6'd0,
          32'h8000_0000, 32'hF800_0000);

    // Signed max/min and pass-C.
    apply("max", 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 3'b100,
          32'hFFFF_FFFB, 32'd0, 32'd3, 32'd0, 6'd0, 6'd0,
          32'hFFFF_FFFB, 32'd3);
    apply("min", 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 3'b101,
          32'hFFFF_FFFB, 32'd0, 32'd3, 32'd0, 6'd0, 6'd0,
          32'hFFFF_FFFB, 32'hFFFF_FFFB);
    apply("passc", 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 3'b111,
          32'd1, 32'd2, 32'hDEAD_BEEF, 32'h55, 6'd0, 6'd0,
          32'h55, 32'hDEAD_BEEF);

    // Mid-operation asynchronous reset, asserted away from any clock edge.
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check_val("arst_pcen", {31'd0, PCEn}, 32'd1);
    check_val("arst_srca", Src1A, 32'd0);
    check_val("arst_signimm", SignImm, 32'd0);
    check_val("arst_rtrd", {20'd0, Rt, Rd}, 32'd0);
    check_val("arst_cntrl", {26'd0, ALU1Cntrl, ALU2Cntrl}, 32'd0);
    check_val("arst_aluout1", ALUOut1, 32'd0);
    check_val("arst_aluout2", ALUOut2, 32'd0);
    check_val("arst_wdst", {26'd0, WriteDstReg}, 32'd0);
    #1;
    RST_N = 1'b1;

    // First edge after reset release captures normally.
    apply("post_rst", 1'b0, 1'b1, 1'b1, 1'b1, 3'b011, 3'b000,
          32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 6'd7, 6'd9,
          32'hF000_F000, 32'hF000_F000);

    // Random vectors checked against the reference model.
    for (int k = 0; k < 40; k++) begin
      ra = $urandom; rb = $urandom; rc = $urandom; ri = $urandom;
      if (k % 5 == 0) ra = 32'h8000_0000;
      o1 = 3'($urandom_range(0, 7));
      o2 = 3'($urandom_range(0, 7));
      s  = 1'($urandom_range(0, 1));
      e1 = ref_alu1(o1, ra, s ? ri : rb);
      apply($sformatf("rnd%0d", k), s, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o1, o2,
            ra, rb, rc, ri, 6'($urandom), 6'($urandom),
            e1, ref_alu2(o2, e1, rc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_ifex_reg
`default_nettype wire
